// File: rtl/arbiter_rr_4.sv
// Four-way round-robin arbiter with a bounded grant hold time and a one-cycle timeout pulse.
// Latency: a request seen in IDLE at edge N is granted from edge N (one cycle req->gnt); release takes one edge.
// Backpressure: none; a grant is held until done, its request drops, or MAX_HOLD expires, and IDLE lasts at least one cycle.
module arbiter_rr_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       busy,
    output logic [1:0] last,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] state;
    logic [7:0] hold_cnt;

    logic [1:0] scan_start;
    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] pick_off;
    logic [1:0] pick_idx;
    logic       expire;
    logic       dropped;
    logic       release_now;

    // Rotate req so the bit after 'last' sits at position 0; lowest set bit wins.
    always_comb begin
        scan_start  = last + 2'd1;
        req_dbl     = {req, req};
        req_rot     = 4'(req_dbl >> scan_start);
        pick_off    = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (req_rot[j]) begin
                pick_off = 2'(j);
            end
        end
        pick_idx    = scan_start + pick_off;
        expire      = (hold_cnt == HOLD_LAST);
        dropped     = ~req[last];
        release_now = done | dropped | expire;
    end

    assign busy = (state == ST_GRANT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= 4'b0000;
            last     <= 2'd3;
            timeout  <= 1'b0;
            hold_cnt <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (req != 4'b0000) begin
                        state    <= ST_GRANT;
                        gnt      <= 4'b0001 << pick_idx;
                        last     <= pick_idx;
                        hold_cnt <= 8'd0;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state   <= ST_IDLE;
                        gnt     <= 4'b0000;
                        // Only a pure expiry is reported; done or a dropped request take precedence.
                        timeout <= expire & ~done & ~dropped;
                    end else begin
                        timeout  <= 1'b0;
                        hold_cnt <= (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    gnt     <= 4'b0000;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_rr_4.sv
// Testbench for arbiter_rr_4: vector table, multi-cycle corner sequences, and a randomized run against a reference model.
module tb_arbiter_rr_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt,  gnt1;
    logic       busy, busy1;
    logic [1:0] last, last1;
    logic       timeout, timeout1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arbiter_rr_4 #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .busy(busy), .last(last), .timeout(timeout)
    );

    arbiter_rr_4 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt1), .busy(busy1), .last(last1), .timeout(timeout1)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] last;
        logic       to;
    } vec_t;

    vec_t vecs[21];

    // Reference model state (MAX_HOLD = 8)
    logic [3:0] m_gnt;
    logic       m_busy;
    logic [1:0] m_last;
    int         m_cnt;
    logic       m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic enc_valid(input logic [3:0] g);
        return g != 4'b0000;
    endfunction

    function automatic logic [1:0] enc_idx(input logic [3:0] g);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] rq, input logic d);
        int idx;
        logic exp_hit, drop;
        if (r) begin
            m_busy = 1'b0; m_gnt = 4'b0000; m_last = 2'd3; m_cnt = 0; m_to = 1'b0;
        end else if (!m_busy) begin
            m_to = 1'b0;
            if (rq != 4'b0000) begin
                idx = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (idx < 0 && rq[(int'(m_last) + k) % 4]) idx = (int'(m_last) + k) % 4;
                end
                m_busy = 1'b1; m_gnt = 4'(1 << idx); m_last = 2'(idx); m_cnt = 0;
            end
        end else begin
            exp_hit = (m_cnt == 7);
            drop    = !rq[m_last];
            if (d || drop || exp_hit) begin
                m_busy = 1'b0; m_gnt = 4'b0000;
                m_to   = exp_hit && !d && !drop;
            end else begin
                m_to  = 1'b0;
                m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
            end
        end
    endtask

    task automatic expiry_race(input logic use_done);
        do_reset();
        req = 4'b0001; done = 1'b0;
        step();
        check("race_grant", gnt, 4'b0001);
        for (int k = 0; k < 7; k++) step();
        check("race_held", gnt, 4'b0001);
        if (use_done) done = 1'b1; else req = 4'b0000;
        step();
        check("race_gnt", gnt, 4'b0000);
        check("race_timeout", timeout, 1'b0);
        done = 1'b0; req = 4'b0000;
        step();
        check("race_timeout_after", timeout, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; done = 1'b0;

        //            rst   req      done  gnt      busy  last   to
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0};
        vecs[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[5]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[7]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0};
        vecs[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[12] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[13] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[14] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[15] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0};
        vecs[16] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[17] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[18] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[19] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[20] = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0};

        for (int v = 0; v < 21; v++) begin
            rst = vecs[v].rst; req = vecs[v].req; done = vecs[v].done;
            step();
            check($sformatf("vec%0d_gnt", v),     gnt,     vecs[v].gnt);
            check($sformatf("vec%0d_busy", v),    busy,    vecs[v].busy);
            check($sformatf("vec%0d_last", v),    last,    vecs[v].last);
            check($sformatf("vec%0d_timeout", v), timeout, vecs[v].to);
        end

        // Expiry with the request held: 8 grant cycles, one-cycle timeout, then re-grant.
        do_reset();
        req = 4'b0100; done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("hold_gnt%0d", k), gnt, 4'b0100);
            check($sformatf("hold_to%0d", k), timeout, 1'b0);
        end
        step();
        check("expire_gnt", gnt, 4'b0000);
        check("expire_busy", busy, 1'b0);
        check("expire_timeout", timeout, 1'b1);
        step();
        check("regrant_gnt", gnt, 4'b0100);
        check("regrant_timeout", timeout, 1'b0);

        // Request drop after three grant cycles.
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 3; k++) step();
        check("drop_held", gnt, 4'b0010);
        req = 4'b0000;
        step();
        check("drop_gnt", gnt, 4'b0000);
        check("drop_timeout", timeout, 1'b0);
        check("drop_last", last, 2'd1);

        expiry_race(1'b1);
        expiry_race(1'b0);

        // Reset during a grant to requester 2.
        do_reset();
        req = 4'b0100;
        step();
        check("rstmid_grant", gnt, 4'b0100);
        step();
        rst = 1'b1;
        step();
        check("rstmid_gnt", gnt, 4'b0000);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_last", last, 2'd3);
        check("rstmid_timeout", timeout, 1'b0);
        rst = 1'b0; req = 4'b0101;
        step();
        check("rstmid_next", gnt, 4'b0001);

        // MAX_HOLD = 1: every grant lasts exactly one cycle.
        do_reset();
        req = 4'b0010;
        step();
        check("mh1_grant", gnt1, 4'b0010);
        step();
        check("mh1_release", gnt1, 4'b0000);
        check("mh1_timeout", timeout1, 1'b1);
        step();
        check("mh1_regrant", gnt1, 4'b0010);
        check("mh1_timeout_clr", timeout1, 1'b0);

        // Randomized run against the reference model.
        do_reset();
        model_step(1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < 10000; c++) begin
            req  = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            step();
            model_step(rst, req, done);
            check("rand_gnt", gnt, m_gnt);
            check("rand_busy", busy, m_busy);
            check("rand_last", last, m_last);
            check("rand_timeout", timeout, m_to);
            check("rand_onehot", ($countones(gnt) <= 1), 1'b1);
            check("rand_onehot1", ($countones(gnt1) <= 1), 1'b1);
            check("rand_enc_valid", enc_valid(gnt), busy);
            check("rand_enc_valid1", enc_valid(gnt1), busy1);
            if (busy) check("rand_enc_idx", enc_idx(gnt), last);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbiter_rr_4.md
ARBITER_RR_4 -- requirements
Module: arbiter_rr_4

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 8, maximum cycles a single grant is held (legal range 1..255).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL provide port rst  input  1  synchronous active-high reset.
REQ-005 SHALL provide port req  input  4  request lines, bit i = requester i, any number may be high.
REQ-006 SHALL provide port done  input  1  current grantee finished; releases the grant.
REQ-007 SHALL provide port gnt  output  4  registered grant; all-zero or exactly one bit high; drives x of the downstream 4-to-2 encoder.
REQ-008 SHALL provide port busy  output  1  registered; high while a grant is held.
REQ-009 SHALL provide port last  output  2  registered index of the most recently granted requester.
REQ-010 SHALL provide port timeout  output  1  registered one-cycle pulse when a grant is released by MAX_HOLD expiry.

Function
REQ-011 SHALL implement two states: IDLE (gnt=0, busy=0) and GRANT (gnt one-hot, busy=1).
REQ-012 SHALL, in IDLE with req!=0 at edge N, select the first asserted bit scanning (last+1), (last+2), (last+3), last modulo 4, and present it on gnt from edge N onward (one-cycle latency req->gnt).
REQ-013 SHALL, on entering GRANT, update last to the selected index and clear the 8-bit hold counter to 0.
REQ-014 SHALL, in IDLE with req=0, stay in IDLE with gnt, last and counter unchanged.
REQ-015 SHALL, in GRANT, increment the hold counter by 1 each cycle, saturating at 255.
REQ-016 SHALL release the grant (next state IDLE, gnt=0, busy=0) when any of: done=1; req[last]=0; hold counter == MAX_HOLD-1.
REQ-017 SHALL assert timeout for exactly the one cycle after release only when release was caused solely by counter expiry (done=0 and req[last]=1 at that edge).
REQ-018 SHALL give done and request-drop priority over expiry: simultaneous done/drop and expiry produce timeout=0.
REQ-019 SHALL spend at least one cycle in IDLE between consecutive grants (gnt=0 for >=1 cycle), so back-to-back grants are never merged.
REQ-020 SHALL ignore done while in IDLE.
REQ-021 SHALL ignore changes on req bits other than req[last] while in GRANT; they are evaluated only at the next IDLE cycle.
REQ-022 SHALL never drive more than one gnt bit high in any cycle, including the cycle after reset and after release.
REQ-023 SHALL with MAX_HOLD=1 release every grant after exactly one GRANT cycle.
REQ-024 SHALL wrap the round-robin scan from index 3 to index 0 without skipping or repeating requesters.

Reset
REQ-025 SHALL, while rst=1 at a rising edge, force state IDLE, gnt=4'b0000, busy=0, last=2'd3, timeout=0, hold counter=0, overriding all other inputs.
REQ-026 SHALL, with last=3 after reset, give requester 0 highest priority on the first arbitration.
REQ-027 SHALL abort a grant in progress when rst is asserted mid-GRANT, with no timeout pulse.

Verification
REQ-028 SHALL cover: reset then req=4'b1111 held, done pulsed each GRANT cycle -> gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-029 SHALL cover: req=4'b0100 held, done=0, MAX_HOLD=8 -> gnt=0100 for 8 cycles, then gnt=0000 with timeout=1 for one cycle, then gnt=0100 again.
REQ-030 SHALL cover: grant to 0010, drop req[1] after 3 cycles -> gnt=0000 next cycle, timeout=0, last=1.
REQ-031 SHALL cover: done=1 on the same edge the counter reaches MAX_HOLD-1 -> release with timeout=0.
REQ-032 SHALL cover: rst=1 mid-GRANT on requester 2 -> next cycle gnt=0000, busy=0, last=3, timeout=0; then req=4'b0101 -> gnt=0001.
REQ-033 SHALL cover: random req/done for >=10000 cycles -> gnt always zero or one-hot, and the downstream encoder's valid output equals busy every cycle.
